// File: rtl/pamiec_pkg.sv
// Shared widths, addresses and state type
// for the memory arbiter.
package pamiec_pkg;

  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 8;
  localparam int STRONY_WIDTH = 4;

  localparam logic [7:0] PAGE_REG_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SET_PAGE,
    ACCESS,
    RESTORE,
    ERROR
  } state_t;

endpackage

// File: rtl/pamiec_arbiter.sv
// CPU/DMA arbiter in front of the paged
// data memory; DMA borrows the page register.
module pamiec_arbiter #(
  parameter int ADDR_WIDTH   = pamiec_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = pamiec_pkg::DATA_WIDTH,
  parameter int STRONY_WIDTH = pamiec_pkg::STRONY_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_wr,
  input  logic [ADDR_WIDTH-1:0]              cpu_adres,
  input  logic [DATA_WIDTH-1:0]              cpu_dane,
  output logic [DATA_WIDTH-1:0]              cpu_out,
  output logic                               cpu_stall,
  input  logic                               dma_req,
  input  logic                               dma_wr,
  input  logic [STRONY_WIDTH+ADDR_WIDTH-1:0] dma_adres,
  input  logic [DATA_WIDTH-1:0]              dma_dane,
  output logic                               dma_ack,
  output logic                               dma_err,
  output logic [DATA_WIDTH-1:0]              dma_out,
  output logic                               mem_wr,
  output logic [ADDR_WIDTH-1:0]              mem_adres,
  output logic [DATA_WIDTH-1:0]              mem_dane,
  input  logic [DATA_WIDTH-1:0]              mem_out
);

  import pamiec_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int SW = STRONY_WIDTH;
  localparam logic [AW-1:0] PG =
    AW'(PAGE_REG_ADDR);

  state_t        state, state_nx;
  logic [SW-1:0] shadow_strona, shadow_nx;
  logic          switched, switched_nx;
  logic          fair, fair_nx;

  logic [SW-1:0] dma_page;
  logic [AW-1:0] dma_off;
  logic          cpu_pg_wr;
  logic [SW-1:0] eff_page;

  assign dma_page  = dma_adres[SW+AW-1:AW];
  assign dma_off   = dma_adres[AW-1:0];
  assign cpu_pg_wr = cpu_wr && (cpu_adres == PG);
  assign eff_page  = cpu_pg_wr ? cpu_dane[SW-1:0]
                               : shadow_strona;

  // State, shadow page and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shadow_strona <= '0;
      switched      <= 1'b0;
      fair          <= 1'b0;
    end else begin
      state         <= state_nx;
      shadow_strona <= shadow_nx;
      switched      <= switched_nx;
      fair          <= fair_nx;
    end
  end

  // Next state and memory/CPU/DMA output mux
  always_comb begin
    state_nx    = state;
    shadow_nx   = shadow_strona;
    switched_nx = switched;
    fair_nx     = 1'b0;
    mem_wr      = cpu_wr;
    mem_adres   = cpu_adres;
    mem_dane    = cpu_dane;
    cpu_out     = mem_out;
    cpu_stall   = 1'b0;
    dma_ack     = 1'b0;
    dma_err     = 1'b0;
    dma_out     = '0;
    unique case (state)
      IDLE: begin
        if (cpu_pg_wr)
          shadow_nx = cpu_dane[SW-1:0];
        if (dma_req && !fair) begin
          if (dma_off == PG) begin
            state_nx = ERROR;
          end else if (dma_page != eff_page) begin
            state_nx    = SET_PAGE;
            switched_nx = 1'b1;
          end else begin
            state_nx    = ACCESS;
            switched_nx = 1'b0;
          end
        end
      end
      SET_PAGE: begin
        mem_wr    = 1'b1;
        mem_adres = PG;
        mem_dane  = DATA_WIDTH'(dma_page);
        cpu_stall = 1'b1;
        state_nx  = ACCESS;
      end
      ACCESS: begin
        mem_wr    = dma_wr;
        mem_adres = dma_off;
        mem_dane  = dma_dane;
        cpu_stall = 1'b1;
        dma_ack   = 1'b1;
        dma_out   = dma_wr ? dma_dane : mem_out;
        state_nx  = switched ? RESTORE : IDLE;
        fair_nx   = !switched;
      end
      RESTORE: begin
        mem_wr      = 1'b1;
        mem_adres   = PG;
        mem_dane    = DATA_WIDTH'(shadow_strona);
        cpu_stall   = 1'b1;
        state_nx    = IDLE;
        switched_nx = 1'b0;
        fair_nx     = 1'b1;
      end
      ERROR: begin
        if (cpu_pg_wr)
          shadow_nx = cpu_dane[SW-1:0];
        dma_ack  = 1'b1;
        dma_err  = 1'b1;
        state_nx = IDLE;
        fair_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pamiec_arbiter.sv
// Bench for pamiec_arbiter with a paged
// memory model and an ack scoreboard.
module tb_pamiec_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_wr;
  logic [7:0]  cpu_adres;
  logic [7:0]  cpu_dane;
  logic [7:0]  cpu_out;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_wr;
  logic [11:0] dma_adres;
  logic [7:0]  dma_dane;
  logic        dma_ack;
  logic        dma_err;
  logic [7:0]  dma_out;
  logic        mem_wr;
  logic [7:0]  mem_adres;
  logic [7:0]  mem_dane;
  logic [7:0]  mem_out;

  pamiec_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wr    (cpu_wr),
    .cpu_adres (cpu_adres),
    .cpu_dane  (cpu_dane),
    .cpu_out   (cpu_out),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_wr    (dma_wr),
    .dma_adres (dma_adres),
    .dma_dane  (dma_dane),
    .dma_ack   (dma_ack),
    .dma_err   (dma_err),
    .dma_out   (dma_out),
    .mem_wr    (mem_wr),
    .mem_adres (mem_adres),
    .mem_dane  (mem_dane),
    .mem_out   (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [7:0] mem [0:15][0:255];
  logic [3:0] page_reg;

  assign mem_out = (mem_adres == 8'hFF) ?
                   {4'b0, page_reg} :
                   mem[page_reg][mem_adres];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      page_reg <= '0;
    end else if (mem_wr) begin
      if (mem_adres == 8'hFF)
        page_reg <= mem_dane[3:0];
      else
        mem[page_reg][mem_adres] <= mem_dane;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk8(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b",
               nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  typedef struct {
    logic [7:0] dout;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic        wr;
    logic [11:0] adr;
    logic [7:0]  dat;
    logic [7:0]  exp_out;
    logic        exp_err;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs[7];

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (dma_ack) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=1 required=0");
        end else begin
          e = sbq.pop_front();
          chk8("ack_dma_out", dma_out, e.dout);
          chk1("ack_dma_err", dma_err, e.err);
          chk_int("ack_cycle", cyc_cnt, e.cyc);
          if (dma_err) begin
            chk1("err_mem_wr", mem_wr, cpu_wr);
            chk8("err_mem_adres", mem_adres, cpu_adres);
          end
        end
      end else begin
        chk8("noack_dma_out", dma_out, 8'h00);
        chk1("noack_dma_err", dma_err, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a,
                           input logic [7:0] d);
    cpu_wr    = 1'b1;
    cpu_adres = a;
    cpu_dane  = d;
    tick();
    cpu_wr    = 1'b0;
    cpu_adres = 8'h00;
  endtask

  task automatic cpu_read(input string nm,
                          input logic [7:0] a,
                          input logic [7:0] req);
    cpu_wr    = 1'b0;
    cpu_adres = a;
    @(negedge clk);
    chk8(nm, cpu_out, req);
    chk1({nm, "_stall"}, cpu_stall, 1'b0);
    tick();
    cpu_adres = 8'h00;
  endtask

  task automatic dma_txn(input string nm,
                         input vec_t v);
    int st;
    bit acked;
    bit now;
    exp_t e;
    dma_req   = 1'b1;
    dma_wr    = v.wr;
    dma_adres = v.adr;
    dma_dane  = v.dat;
    e.dout = v.exp_out;
    e.err  = v.exp_err;
    e.cyc  = cyc_cnt + v.lat;
    sbq.push_back(e);
    st    = 0;
    acked = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_stall) st++;
      now = dma_ack;
      tick();
      if (now) begin
        dma_req = 1'b0;
        acked   = 1'b1;
      end
    end
    chk_int({nm, "_stall_cycles"}, st, v.stall);
    chk1({nm, "_acked"}, acked, 1'b1);
  endtask

  initial begin
    int nack;
    int gap;
    bit now;
    exp_t e;
    vec_t v;

    vecs[0] = '{1'b0, 12'h503, 8'h00, 8'h3C, 1'b0, 1, 1};
    vecs[1] = '{1'b1, 12'h510, 8'h55, 8'h55, 1'b0, 1, 1};
    vecs[2] = '{1'b0, 12'h510, 8'h00, 8'h55, 1'b0, 1, 1};
    vecs[3] = '{1'b1, 12'h932, 8'hC4, 8'hC4, 1'b0, 2, 3};
    vecs[4] = '{1'b0, 12'h932, 8'h00, 8'hC4, 1'b0, 2, 3};
    vecs[5] = '{1'b0, 12'h2FF, 8'h00, 8'h00, 1'b1, 1, 0};
    vecs[6] = '{1'b0, 12'h503, 8'h00, 8'h3C, 1'b0, 1, 1};

    rst       = 1'b0;
    cpu_wr    = 1'b0;
    cpu_adres = 8'h00;
    cpu_dane  = 8'h00;
    dma_req   = 1'b0;
    dma_wr    = 1'b0;
    dma_adres = 12'h000;
    dma_dane  = 8'h00;

    #2;
    chk1("rst_stall", cpu_stall, 1'b0);
    chk1("rst_ack", dma_ack, 1'b0);
    chk1("rst_err", dma_err, 1'b0);
    chk8("rst_dma_out", dma_out, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();

    cpu_read("rst_page_reg", 8'hFF, 8'h00);

    dma_req   = 1'b1;
    dma_wr    = 1'b1;
    dma_adres = 12'h932;
    dma_dane  = 8'hA7;
    e.dout = 8'hA7;
    e.err  = 1'b0;
    e.cyc  = cyc_cnt + 2;
    sbq.push_back(e);
    @(negedge clk);
    chk1("sw_idle_stall", cpu_stall, 1'b0);
    tick();
    @(negedge clk);
    chk1("sw_set_wr", mem_wr, 1'b1);
    chk8("sw_set_adres", mem_adres, 8'hFF);
    chk8("sw_set_dane", mem_dane, 8'h09);
    chk1("sw_set_stall", cpu_stall, 1'b1);
    chk1("sw_set_ack", dma_ack, 1'b0);
    tick();
    @(negedge clk);
    chk1("sw_acc_ack", dma_ack, 1'b1);
    chk1("sw_acc_wr", mem_wr, 1'b1);
    chk8("sw_acc_adres", mem_adres, 8'h32);
    chk8("sw_acc_dane", mem_dane, 8'hA7);
    chk1("sw_acc_stall", cpu_stall, 1'b1);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    chk1("sw_rst_wr", mem_wr, 1'b1);
    chk8("sw_rst_adres", mem_adres, 8'hFF);
    chk8("sw_rst_dane", mem_dane, 8'h00);
    chk1("sw_rst_stall", cpu_stall, 1'b1);
    tick();
    @(negedge clk);
    chk1("sw_after_stall", cpu_stall, 1'b0);
    tick();
    cpu_read("sw_page_after", 8'hFF, 8'h00);

    cpu_write(8'hFF, 8'h05);
    cpu_read("cpu_page5", 8'hFF, 8'h05);
    cpu_write(8'h03, 8'h3C);
    cpu_read("cpu_fill", 8'h03, 8'h3C);

    for (int i = 0; i < 7; i++) begin
      dma_txn($sformatf("vec%0d", i), vecs[i]);
    end
    cpu_read("page_kept", 8'hFF, 8'h05);

    dma_req   = 1'b1;
    dma_wr    = 1'b0;
    dma_adres = 12'h503;
    e.dout = 8'h3C;
    e.err  = 1'b0;
    e.cyc  = cyc_cnt + 1;
    sbq.push_back(e);
    e.cyc  = cyc_cnt + 4;
    sbq.push_back(e);
    nack = 0;
    gap  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      now = dma_ack;
      if (now) nack++;
      else if (nack == 1 && !cpu_stall) gap++;
      tick();
      if (now && nack == 2) dma_req = 1'b0;
    end
    chk_int("fair_acks", nack, 2);
    chk1("fair_gap", gap >= 1, 1'b1);

    dma_req   = 1'b1;
    dma_wr    = 1'b0;
    dma_adres = 12'hA10;
    tick();
    chk1("mid_set_stall", cpu_stall, 1'b1);
    chk8("mid_set_adres", mem_adres, 8'hFF);
    #1;
    rst = 1'b0;
    #1;
    chk1("mid_rst_stall", cpu_stall, 1'b0);
    chk1("mid_rst_ack", dma_ack, 1'b0);
    chk1("mid_rst_wr", mem_wr, cpu_wr);
    chk8("mid_rst_adres", mem_adres, cpu_adres);
    dma_req = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    cpu_read("mid_rst_page", 8'hFF, 8'h00);
    cpu_write(8'h03, 8'h11);
    v = '{1'b0, 12'h003, 8'h00, 8'h11, 1'b0, 1, 1};
    dma_txn("post_rst", v);

    chk_int("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pamiec_arbiter.md
PAMIEC_ARBITER -- requirements
Module: pamiec_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, memory offset width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, data width.
REQ-003 The block SHALL have parameter STRONY_WIDTH, default 4, page number width.
REQ-004 The block SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports cpu_wr in 1 / cpu_adres in 8 / cpu_dane in 8, the single-cycle CPU request.
REQ-007 The block SHALL have ports cpu_out out 8 and cpu_stall out 1; while cpu_stall=1 the CPU holds its state.
REQ-008 The block SHALL have ports dma_req in 1 / dma_wr in 1 / dma_adres in 12 ({page[3:0], offset[7:0]}) / dma_dane in 8.
REQ-009 The block SHALL have ports dma_ack out 1, dma_err out 1 and dma_out out 8.
REQ-010 The block SHALL have ports mem_wr out 1 / mem_adres out 8 / mem_dane out 8 / mem_out in 8, connected to pamiec_data.

Function
REQ-011 States: IDLE, SET_PAGE, ACCESS, RESTORE, ERROR.
REQ-012 Shadow page register shadow_strona (4 bit) SHALL track the memory page register.
- Update: IDLE/ERROR with cpu_wr=1 and cpu_adres=0xFF -> shadow_strona <= cpu_dane[3:0].
REQ-013 IDLE/ERROR: CPU passthrough, combinational.
- mem_wr=cpu_wr, mem_adres=cpu_adres, mem_dane=cpu_dane, cpu_out=mem_out, cpu_stall=0.
REQ-014 IDLE, dma_req=1, offset=0xFF -> ERROR.
REQ-015 IDLE, dma_req=1, page!=shadow_strona -> SET_PAGE.
REQ-016 IDLE, dma_req=1, page==shadow_strona -> ACCESS.
REQ-017 IDLE, dma_req=0 -> stay IDLE.
REQ-018 The IDLE cycle in which dma_req is first seen SHALL still serve the CPU unstalled.
REQ-019 SET_PAGE: mem_wr=1, mem_adres=0xFF, mem_dane={4'b0,dma page}, cpu_stall=1; next ACCESS.
REQ-020 ACCESS: mem_wr=dma_wr, mem_adres=dma offset, mem_dane=dma_dane, cpu_stall=1.
- Same cycle: dma_ack=1, dma_out=mem_out; write-through makes dma_out=dma_dane on writes.
REQ-021 ACCESS -> RESTORE if the page was switched, else -> IDLE.
REQ-022 RESTORE: mem_wr=1, mem_adres=0xFF, mem_dane={4'b0,shadow_strona}, cpu_stall=1; next IDLE.
REQ-023 ERROR: dma_ack=1, dma_err=1 for one cycle, no DMA memory access, CPU unstalled; next IDLE.
REQ-024 Fairness: the cycle after ACCESS/RESTORE/ERROR SHALL be IDLE serving the CPU; no DMA transition is taken from that cycle.
REQ-025 dma_ack and dma_err SHALL each be single-cycle pulses, 0 outside ACCESS/ERROR.
REQ-026 dma_out SHALL be 0 outside ACCESS.
REQ-027 The DMA requester SHALL hold dma_* stable from assertion until ack; it deasserts or presents a new request the cycle after ack.
REQ-028 Latency, in cycles from the IDLE sample to ack:
- same page: 1
- page switch: 2, plus 1 RESTORE cycle
- error: 1
REQ-029 CPU stall per DMA access: 1 cycle same page, 3 cycles with page switch.

Reset
REQ-030 On rst=0 the block SHALL immediately enter IDLE with shadow_strona=0, dma_ack=0, dma_err=0, dma_out=0 and cpu_stall=0.
- Asynchronous; valid mid-SET_PAGE/ACCESS/RESTORE.
REQ-031 The same system reset SHALL clear the memory page register, keeping shadow_strona consistent; an aborted DMA access is not acked.

Structure
REQ-032 Package pamiec_pkg SHALL hold:
- ADDR_WIDTH, DATA_WIDTH, STRONY_WIDTH
- PAGE_REG_ADDR = 8'hFF
- state enum type
REQ-033 Single module, no sub-module; one state register, shadow_strona register and a switched-flag register, plus a combinational output mux.

Verification
REQ-034 Reset, then CPU writes 0x5 to 0xFF -> shadow_strona=5, no stall.
- Then DMA read of 0x503 (pre-filled 0x3C) -> ACCESS in 1 cycle, dma_out=0x3C, no SET_PAGE.
REQ-035 Shadow page 0, DMA write 0x932=0xA7 -> SET_PAGE (mem_dane 0x09), ACCESS (ack, dma_out=0xA7), RESTORE (mem_dane 0x00).
- cpu_stall high exactly 3 cycles; CPU read of 0xFF afterwards returns 0x00.
REQ-036 DMA request to 0x2FF -> one cycle ack+err, mem_wr follows cpu_wr, memory offset 0xFF unchanged.
REQ-037 dma_req held continuously for two requests -> at least one unstalled CPU cycle between the two ACCESS cycles.
REQ-038 rst=0 asserted during SET_PAGE -> IDLE the same cycle, no ack, shadow_strona=0, cpu_stall=0.
